// File: rtl/chacha_pkg.sv
// Shared types, widths and helpers for the ChaCha20-Poly1305 AEAD message sequencer.
package chacha_pkg;

    localparam int BLK_W      = 128;
    localparam int KEEP_W     = 16;
    localparam int LEN_HALF_W = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_AAD  = 3'd1;
    localparam state_t ST_PLD  = 3'd2;
    localparam state_t ST_LEN  = 3'd3;
    localparam state_t ST_TAG  = 3'd4;
    localparam state_t ST_DONE = 3'd5;

    function automatic logic [4:0] popcount16(input logic [KEEP_W-1:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {4'd0, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/chacha20_poly1305_aead_ctrl_if.sv
// Block-wide byte stream: valid/ready handshake with data, byte keep and end-of-message flag.
interface chacha20_poly1305_aead_ctrl_if;
    import chacha_pkg::*;

    logic              valid;
    logic              ready;
    logic [BLK_W-1:0]  data;
    logic [KEEP_W-1:0] keep;
    logic              last;

    modport master (output valid, data, keep, last, input ready);
    modport slave  (input valid, data, keep, last, output ready);

endinterface

// File: rtl/chacha_tag_capture.sv
// Latches tagmask / tag_pre_xor from the core in any order and forms the final tag and verdict.
module chacha_tag_capture
    import chacha_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_in_tag,
    input  logic             i_decrypt,
    input  logic [BLK_W-1:0] i_exp_tag,
    input  logic [BLK_W-1:0] i_tag_pre_xor,
    input  logic             i_tag_pre_xor_valid,
    input  logic [BLK_W-1:0] i_tagmask,
    input  logic             i_tagmask_valid,
    output logic             o_fire,
    output logic [BLK_W-1:0] o_tag,
    output logic             o_tag_valid,
    output logic             o_tag_ok
);

    logic [BLK_W-1:0] r_pre, r_mask, r_tag;
    logic             r_pre_f, r_mask_f, r_tag_valid, r_tag_ok;
    logic [BLK_W-1:0] w_pre, w_mask, w_tag;
    logic             w_pre_f, w_mask_f;

    // A value arriving this cycle counts as captured, so the tag lands one cycle after it.
    assign w_pre    = i_tag_pre_xor_valid ? i_tag_pre_xor : r_pre;
    assign w_mask   = i_tagmask_valid ? i_tagmask : r_mask;
    assign w_pre_f  = r_pre_f | i_tag_pre_xor_valid;
    assign w_mask_f = r_mask_f | i_tagmask_valid;
    assign w_tag    = w_pre ^ w_mask;
    assign o_fire   = i_in_tag & w_pre_f & w_mask_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_mask      <= '0;
            r_pre_f     <= 1'b0;
            r_mask_f    <= 1'b0;
            r_tag       <= '0;
            r_tag_valid <= 1'b0;
            r_tag_ok    <= 1'b0;
        end else begin
            r_tag_valid <= o_fire;
            if (i_tag_pre_xor_valid) r_pre  <= i_tag_pre_xor;
            if (i_tagmask_valid)     r_mask <= i_tagmask;
            if (i_clear) begin
                r_pre_f  <= i_tag_pre_xor_valid;
                r_mask_f <= i_tagmask_valid;
                r_tag_ok <= 1'b0;
            end else begin
                r_pre_f  <= w_pre_f;
                r_mask_f <= w_mask_f;
            end
            if (o_fire) begin
                r_tag    <= w_tag;
                r_tag_ok <= i_decrypt ? (w_tag == i_exp_tag) : 1'b1;
            end
        end
    end

    assign o_tag       = r_tag;
    assign o_tag_valid = r_tag_valid;
    assign o_tag_ok    = r_tag_ok;

endmodule

// File: rtl/chacha20_poly1305_aead_ctrl.sv
// Message sequencer: forwards AAD/payload to the core, issues the length block, emits the tag.
module chacha20_poly1305_aead_ctrl
    import chacha_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    input  logic                  i_no_aad,
    input  logic                  i_no_pld,
    input  logic                  i_decrypt,
    input  logic [BLK_W-1:0]      i_exp_tag,
    chacha20_poly1305_aead_ctrl_if.slave  s_aad,
    chacha20_poly1305_aead_ctrl_if.slave  s_pld,
    chacha20_poly1305_aead_ctrl_if.master m_aad,
    chacha20_poly1305_aead_ctrl_if.master m_pld,
    output logic                  o_len_valid,
    input  logic                  i_len_ready,
    output logic [BLK_W-1:0]      o_len_block,
    input  logic [BLK_W-1:0]      i_tag_pre_xor,
    input  logic                  i_tag_pre_xor_valid,
    input  logic [BLK_W-1:0]      i_tagmask,
    input  logic                  i_tagmask_valid,
    output logic [BLK_W-1:0]      o_tag,
    output logic                  o_tag_valid,
    output logic                  o_tag_ok,
    output logic                  o_busy,
    output logic [LEN_HALF_W-1:0] o_aad_bytes,
    output logic [LEN_HALF_W-1:0] o_pld_bytes
);

    state_t                r_state, w_state_nxt;
    logic                  r_no_pld, r_decrypt, r_len_valid;
    logic [LEN_HALF_W-1:0] r_aad_bytes, r_pld_bytes;
    logic                  w_start, w_in_aad, w_in_pld, w_aad_hs, w_pld_hs, w_len_hs, w_tag_fire;

    assign w_start  = i_start && (r_state == ST_IDLE);
    assign w_in_aad = (r_state == ST_AAD);
    assign w_in_pld = (r_state == ST_PLD);
    assign w_aad_hs = w_in_aad && s_aad.valid && m_aad.ready;
    assign w_pld_hs = w_in_pld && s_pld.valid && m_pld.ready;
    assign w_len_hs = r_len_valid && i_len_ready;

    always_comb begin
        m_aad.valid = w_in_aad && s_aad.valid;
        m_aad.data  = s_aad.data;
        m_aad.keep  = s_aad.keep;
        m_aad.last  = 1'b0;
        s_aad.ready = w_in_aad && m_aad.ready;
        m_pld.valid = w_in_pld && s_pld.valid;
        m_pld.data  = s_pld.data;
        m_pld.keep  = s_pld.keep;
        m_pld.last  = 1'b0;
        s_pld.ready = w_in_pld && m_pld.ready;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = !i_no_aad ? ST_AAD : (i_no_pld ? ST_LEN : ST_PLD);
            ST_AAD:  if (w_aad_hs && s_aad.last) w_state_nxt = r_no_pld ? ST_LEN : ST_PLD;
            ST_PLD:  if (w_pld_hs && s_pld.last) w_state_nxt = ST_LEN;
            ST_LEN:  if (w_len_hs) w_state_nxt = ST_TAG;
            ST_TAG:  if (w_tag_fire) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_no_pld    <= 1'b0;
            r_decrypt   <= 1'b0;
            r_len_valid <= 1'b0;
            r_aad_bytes <= '0;
            r_pld_bytes <= '0;
        end else begin
            r_state     <= w_state_nxt;
            // Raised the cycle after LEN entry, dropped on the handshake that leaves LEN.
            r_len_valid <= (r_state == ST_LEN) && !w_len_hs;
            if (w_start) begin
                r_no_pld    <= i_no_pld;
                r_decrypt   <= i_decrypt;
                r_aad_bytes <= '0;
                r_pld_bytes <= '0;
            end else begin
                if (w_aad_hs) r_aad_bytes <= r_aad_bytes + LEN_HALF_W'(popcount16(s_aad.keep));
                if (w_pld_hs) r_pld_bytes <= r_pld_bytes + LEN_HALF_W'(popcount16(s_pld.keep));
            end
        end
    end

    chacha_tag_capture u_tag_capture (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_clear             (w_start),
        .i_in_tag            (r_state == ST_TAG),
        .i_decrypt           (r_decrypt),
        .i_exp_tag           (i_exp_tag),
        .i_tag_pre_xor       (i_tag_pre_xor),
        .i_tag_pre_xor_valid (i_tag_pre_xor_valid),
        .i_tagmask           (i_tagmask),
        .i_tagmask_valid     (i_tagmask_valid),
        .o_fire              (w_tag_fire),
        .o_tag               (o_tag),
        .o_tag_valid         (o_tag_valid),
        .o_tag_ok            (o_tag_ok)
    );

    assign o_len_valid = r_len_valid;
    assign o_len_block = {r_pld_bytes, r_aad_bytes};
    assign o_busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_aad_bytes = r_aad_bytes;
    assign o_pld_bytes = r_pld_bytes;

endmodule

// File: tb/tb_chacha20_poly1305_aead_ctrl.sv
// Self-checking bench: message table plus hand-written timing and reset-abort sequences.
module tb_chacha20_poly1305_aead_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_start = 1'b0, i_no_aad = 1'b0, i_no_pld = 1'b0, i_decrypt = 1'b0;
    logic [127:0] i_exp_tag = '0;
    logic         o_len_valid;
    logic         i_len_ready = 1'b0;
    logic [127:0] o_len_block;
    logic [127:0] i_tag_pre_xor = '0, i_tagmask = '0;
    logic         i_tag_pre_xor_valid = 1'b0, i_tagmask_valid = 1'b0;
    logic [127:0] o_tag;
    logic         o_tag_valid, o_tag_ok, o_busy;
    logic [63:0]  o_aad_bytes, o_pld_bytes;
    bit           bp = 1'b0;

    chacha20_poly1305_aead_ctrl_if s_aad_if ();
    chacha20_poly1305_aead_ctrl_if s_pld_if ();
    chacha20_poly1305_aead_ctrl_if m_aad_if ();
    chacha20_poly1305_aead_ctrl_if m_pld_if ();

    chacha20_poly1305_aead_ctrl dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start             (i_start),
        .i_no_aad            (i_no_aad),
        .i_no_pld            (i_no_pld),
        .i_decrypt           (i_decrypt),
        .i_exp_tag           (i_exp_tag),
        .s_aad               (s_aad_if),
        .s_pld               (s_pld_if),
        .m_aad               (m_aad_if),
        .m_pld               (m_pld_if),
        .o_len_valid         (o_len_valid),
        .i_len_ready         (i_len_ready),
        .o_len_block         (o_len_block),
        .i_tag_pre_xor       (i_tag_pre_xor),
        .i_tag_pre_xor_valid (i_tag_pre_xor_valid),
        .i_tagmask           (i_tagmask),
        .i_tagmask_valid     (i_tagmask_valid),
        .o_tag               (o_tag),
        .o_tag_valid         (o_tag_valid),
        .o_tag_ok            (o_tag_ok),
        .o_busy              (o_busy),
        .o_aad_bytes         (o_aad_bytes),
        .o_pld_bytes         (o_pld_bytes)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
    } beat_t;

    typedef struct {
        int           naad;
        logic [15:0]  aad_lk;
        int           npld;
        logic [15:0]  pld_lk;
        bit           no_aad, no_pld, dec, flip, same, bp;
        int           lendly;
        logic [63:0]  exp_lo, exp_hi;
        logic [127:0] mask, pre;
    } vec_t;

    vec_t         vecs [7];
    beat_t        aad_q[$], pld_q[$];
    logic [127:0] tag_q[$];
    logic         ok_q[$];
    int           total = 0, bad = 0, tv_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic fail_to(input string name);
        total++;
        bad++;
        $display("FAIL %s act=timeout exp=event", name);
    endtask

    // Core-side ready for AAD: steady, or toggling every cycle under backpressure.
    always @(posedge clk) begin
        #1;
        if (bp) m_aad_if.ready = ~m_aad_if.ready;
        else    m_aad_if.ready = 1'b1;
    end

    // Scoreboard: pops on every core-side handshake and every tag pulse.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && m_aad_if.valid && m_aad_if.ready) begin
            if (aad_q.size() == 0) chk("aad_extra_beat", 1, 0);
            else begin
                e = aad_q.pop_front();
                chk("aad_data", m_aad_if.data, e.d);
                chk("aad_keep", {112'd0, m_aad_if.keep}, {112'd0, e.k});
            end
        end
        if (rst_n && m_pld_if.valid && m_pld_if.ready) begin
            if (pld_q.size() == 0) chk("pld_extra_beat", 1, 0);
            else begin
                e = pld_q.pop_front();
                chk("pld_data", m_pld_if.data, e.d);
                chk("pld_keep", {112'd0, m_pld_if.keep}, {112'd0, e.k});
            end
        end
        if (o_tag_valid) begin
            tv_cnt++;
            if (tag_q.size() == 0) chk("tag_valid_unexpected", 1, 0);
            else begin
                chk("tag", o_tag, tag_q.pop_front());
                chk("tag_ok", {127'd0, o_tag_ok}, {127'd0, ok_q.pop_front()});
            end
        end
    end

    task automatic drive_beat(input bit is_pld, input logic [15:0] k, input bit last);
        beat_t b;
        bit    hs;
        b.d = {$urandom, $urandom, $urandom, $urandom};
        b.k = k;
        hs  = 1'b0;
        if (is_pld) begin
            pld_q.push_back(b);
            s_pld_if.valid = 1'b1; s_pld_if.data = b.d; s_pld_if.keep = k; s_pld_if.last = last;
        end else begin
            aad_q.push_back(b);
            s_aad_if.valid = 1'b1; s_aad_if.data = b.d; s_aad_if.keep = k; s_aad_if.last = last;
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (is_pld ? s_pld_if.ready : s_aad_if.ready) begin
                hs = 1'b1;
                break;
            end
        end
        if (!hs) fail_to(is_pld ? "pld_handshake" : "aad_handshake");
        @(posedge clk); #1;
        s_aad_if.valid = 1'b0;
        s_pld_if.valid = 1'b0;
    endtask

    task automatic run_msg(input vec_t v);
        logic [127:0] t_exp, e_tag;
        int           tv0;
        bit           got;
        t_exp = v.pre ^ v.mask;
        e_tag = v.flip ? (t_exp ^ (128'd1 << 77)) : (v.dec ? t_exp : ~t_exp);
        tag_q.push_back(t_exp);
        ok_q.push_back(v.dec ? (e_tag == t_exp) : 1'b1);
        tv0 = tv_cnt;
        @(posedge clk); #1;
        i_no_aad = v.no_aad; i_no_pld = v.no_pld; i_decrypt = v.dec; i_exp_tag = e_tag;
        bp = v.bp; i_tagmask = v.mask; i_tag_pre_xor = v.pre;
        i_start = 1'b1;
        @(posedge clk); #1;
        // Second start while busy, with different mode bits: must have no effect.
        i_no_aad = 1'b1; i_no_pld = 1'b1; i_decrypt = ~v.dec;
        if (!v.same) i_tagmask_valid = 1'b1;
        @(negedge clk);
        chk("busy_after_start", {127'd0, o_busy}, 128'd1);
        @(posedge clk); #1;
        i_start = 1'b0; i_tagmask_valid = 1'b0;
        if (!v.no_aad) for (int b = 0; b < v.naad; b++)
            drive_beat(1'b0, (b == v.naad - 1) ? v.aad_lk : 16'hFFFF, b == v.naad - 1);
        if (!v.no_pld) for (int b = 0; b < v.npld; b++)
            drive_beat(1'b1, (b == v.npld - 1) ? v.pld_lk : 16'hFFFF, b == v.npld - 1);
        got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (o_len_valid) begin got = 1'b1; break; end
        end
        if (!got) fail_to("len_valid");
        else begin
            chk("len_lo", {64'd0, o_len_block[63:0]}, {64'd0, v.exp_lo});
            chk("len_hi", {64'd0, o_len_block[127:64]}, {64'd0, v.exp_hi});
            for (int k = 0; k < v.lendly; k++) begin
                @(negedge clk);
                chk("len_hold_valid", {127'd0, o_len_valid}, 128'd1);
                chk("len_hold_block", o_len_block, {v.exp_hi, v.exp_lo});
            end
            @(posedge clk); #1; i_len_ready = 1'b1;
            @(posedge clk); #1; i_len_ready = 1'b0;
        end
        i_tag_pre_xor_valid = 1'b1;
        if (v.same) i_tagmask_valid = 1'b1;
        @(posedge clk); #1;
        i_tag_pre_xor_valid = 1'b0; i_tagmask_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (o_tag_valid) begin got = 1'b1; break; end
        end
        if (!got) begin
            fail_to("tag_valid");
            tag_q.delete(); ok_q.delete();
        end else begin
            chk("busy_in_done", {127'd0, o_busy}, 128'd0);
            chk("aad_bytes", {64'd0, o_aad_bytes}, {64'd0, v.exp_lo});
            chk("pld_bytes", {64'd0, o_pld_bytes}, {64'd0, v.exp_hi});
            @(negedge clk);
            chk("tag_valid_single", {127'd0, o_tag_valid}, 128'd0);
            chk("tag_pulse_count", tv_cnt - tv0, 1);
        end
        bp = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] mask, pre;
        s_aad_if.valid = 1'b0; s_aad_if.data = '0; s_aad_if.keep = '0; s_aad_if.last = 1'b0;
        s_pld_if.valid = 1'b0; s_pld_if.data = '0; s_pld_if.keep = '0; s_pld_if.last = 1'b0;
        m_pld_if.ready = 1'b1;

        vecs[0] = '{10, 16'hFFFF, 10, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,
                    64'd160, 64'd160, {16{8'h0F}}, {16{8'hF0}}};
        vecs[1] = '{1, 16'h1FFF, 2, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0,
                    64'd13, 64'd19, 128'h0123456789abcdef_fedcba9876543210, 128'h5a5a_1111_2222_3333};
        vecs[2] = '{2, 16'hFFFF, 1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1,
                    64'd32, 64'd0, 128'hdeadbeef_00000000_cafef00d_12345678, 128'h77};
        vecs[3] = '{1, 16'hFFFF, 3, 16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2,
                    64'd16, 64'd40, 128'h1, 128'hffff_0000_ffff_0000_1234_5678_9abc_def0};
        vecs[4] = '{5, 16'h000F, 2, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4,
                    64'd68, 64'd32, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 128'h3c};
        vecs[5] = '{3, 16'h0001, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0,
                    64'd33, 64'd0, 128'h42, 128'h24};
        vecs[6] = '{0, 16'h0000, 4, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1,
                    64'd0, 64'd63, 128'habcd, 128'hdcba_0000_0000_0000_0000_0000_0000_0000};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", {127'd0, o_busy}, 128'd0);
        chk("rst_len_valid", {127'd0, o_len_valid}, 128'd0);
        chk("rst_tag", o_tag, 128'd0);
        chk("rst_tag_valid", {127'd0, o_tag_valid}, 128'd0);
        chk("rst_tag_ok", {127'd0, o_tag_ok}, 128'd0);
        chk("rst_counts", {o_pld_bytes, o_aad_bytes}, 128'd0);
        chk("rst_aad_ready", {127'd0, s_aad_if.ready}, 128'd0);
        chk("rst_core_valid", {126'd0, m_aad_if.valid, m_pld_if.valid}, 128'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_msg(vecs[i]);

        // No AAD, no payload: straight to LEN, tag one cycle after a late pre_xor.
        mask = {$urandom, $urandom, $urandom, $urandom};
        pre  = {$urandom, $urandom, $urandom, $urandom};
        tag_q.push_back(mask ^ pre);
        ok_q.push_back(1'b1);
        @(posedge clk); #1;
        i_no_aad = 1'b1; i_no_pld = 1'b1; i_decrypt = 1'b0; i_start = 1'b1;
        i_tagmask = mask; i_tag_pre_xor = pre;
        @(posedge clk); #1;
        i_start = 1'b0; i_tagmask_valid = 1'b1;
        @(negedge clk);
        chk("skip_len_not_yet", {127'd0, o_len_valid}, 128'd0);
        @(posedge clk); #1;
        i_tagmask_valid = 1'b0;
        @(negedge clk);
        chk("skip_len_valid", {127'd0, o_len_valid}, 128'd1);
        chk("skip_len_block", o_len_block, 128'd0);
        i_len_ready = 1'b1;
        @(posedge clk); #1; i_len_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("skip_no_early_tag", {127'd0, o_tag_valid}, 128'd0);
            @(posedge clk); #1;
        end
        i_tag_pre_xor_valid = 1'b1;
        @(negedge clk);
        chk("skip_tag_not_same_cycle", {127'd0, o_tag_valid}, 128'd0);
        @(posedge clk); #1; i_tag_pre_xor_valid = 1'b0;
        @(negedge clk);
        chk("skip_tag_latency", {127'd0, o_tag_valid}, 128'd1);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-payload aborts with no tag, then a fresh message counts from zero.
        i_no_aad = 1'b0; i_no_pld = 1'b0; i_start = 1'b1; i_tagmask_valid = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_tagmask_valid = 1'b0;
        drive_beat(1'b0, 16'hFFFF, 1'b1);
        for (int b = 0; b < 3; b++) drive_beat(1'b1, 16'hFFFF, 1'b0);
        i_tag_pre_xor_valid = 1'b1;
        @(posedge clk); #1; i_tag_pre_xor_valid = 1'b0;
        @(negedge clk);
        chk("abort_pld_bytes", {64'd0, o_pld_bytes}, 128'd48);
        chk("abort_aad_bytes", {64'd0, o_aad_bytes}, 128'd16);
        @(posedge clk); #1; rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {127'd0, o_busy}, 128'd0);
        chk("abort_counts", {o_pld_bytes, o_aad_bytes}, 128'd0);
        chk("abort_len_valid", {127'd0, o_len_valid}, 128'd0);
        chk("abort_pld_valid", {127'd0, m_pld_if.valid}, 128'd0);
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        run_msg(vecs[1]);

        chk("aad_q_empty", aad_q.size(), 0);
        chk("pld_q_empty", pld_q.size(), 0);
        chk("tag_q_empty", tag_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
